// File: rtl/wb_scoreboard.sv
// Write-back and hazard stage in front of the register bank.
// ALU results are buffered in a small FIFO and drained through a registered
// write port. A per-register pending mask drives the decode stall (RAW/WAW).
module wb_scoreboard #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned NREGS      = 2**ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              issue_valid,
  output logic              issue_ready,
  input  logic [ADDR_W-1:0] issue_src1,
  input  logic [ADDR_W-1:0] issue_src2,
  input  logic [ADDR_W-1:0] issue_dest,
  input  logic              issue_writes,
  input  logic              res_valid,
  output logic              res_ready,
  input  logic [ADDR_W-1:0] res_dest,
  input  logic [DATA_W-1:0] res_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  input  logic              wr_hold,
  output logic [NREGS-1:0]  busy_mask,
  output logic              err
);

  localparam int unsigned PtrW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [ADDR_W-1:0] fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data [FIFO_DEPTH];
  logic [PtrW-1:0]   rd_ptr;
  logic [PtrW-1:0]   wr_ptr;
  logic [CntW-1:0]   count;
  logic [CntW-1:0]   count_next;
  logic [NREGS-1:0]  busy_next;

  logic fifo_empty;
  logic fifo_full;
  logic accept;
  logic retire;
  logic load_ok;
  logic pop;
  logic push;
  logic issue_fire;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    if (p == PtrW'(FIFO_DEPTH - 1)) begin
      return '0;
    end else begin
      return p + 1'b1;
    end
  endfunction

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CntW'(FIFO_DEPTH));
  assign res_ready  = ~fifo_full;
  assign accept     = res_valid & res_ready;
  assign retire     = wr_en & ~wr_hold;
  assign load_ok    = ~wr_en | ~wr_hold;
  assign pop        = load_ok & ~fifo_empty;
  // An accepted result skips the FIFO only when it is empty and the output can load.
  assign push       = accept & ~(load_ok & fifo_empty);

  assign issue_ready = ~(busy_mask[issue_src1] | busy_mask[issue_src2] |
                         (issue_writes & busy_mask[issue_dest]));
  assign issue_fire  = issue_valid & issue_ready & issue_writes;

  // Next occupancy from push/pop; a full FIFO never accepts so it cannot overflow.
  always_comb begin
    count_next = count;
    unique case ({push, pop})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Scoreboard update: retire clears, issue sets; set is applied last so it wins.
  always_comb begin
    busy_next = busy_mask;
    if (retire) begin
      busy_next[wr_addr] = 1'b0;
    end
    if (issue_fire) begin
      busy_next[issue_dest] = 1'b1;
    end
  end

  // FIFO storage needs no reset; occupancy decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= res_dest;
      fifo_data[wr_ptr] <= res_data;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      if (pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
      end
      count <= count_next;
    end
  end

  // Registered write port: FIFO head first, then bypass, else go idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else if (load_ok) begin
      if (!fifo_empty) begin
        wr_en   <= 1'b1;
        wr_addr <= fifo_addr[rd_ptr];
        wr_data <= fifo_data[rd_ptr];
      end else if (accept) begin
        wr_en   <= 1'b1;
        wr_addr <= res_dest;
        wr_data <= res_data;
      end else begin
        wr_en <= 1'b0;
      end
    end
  end

  // Pending mask and sticky error for results that nobody was waiting on.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_mask <= '0;
      err       <= 1'b0;
    end else begin
      busy_mask <= busy_next;
      if (accept && !busy_mask[res_dest]) begin
        err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_wb_scoreboard.sv
// Bench for wb_scoreboard: hazard vector table, directed multi-cycle sequences,
// and a queue of expected bank writes checked whenever a write retires.
module tb_wb_scoreboard;

  logic        clk;
  logic        rst_n;
  logic        issue_valid;
  logic        issue_ready;
  logic [2:0]  issue_src1;
  logic [2:0]  issue_src2;
  logic [2:0]  issue_dest;
  logic        issue_writes;
  logic        res_valid;
  logic        res_ready;
  logic [2:0]  res_dest;
  logic [15:0] res_data;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        wr_hold;
  logic [7:0]  busy_mask;
  logic        err;

  int total = 0;
  int bad   = 0;

  logic [18:0] sb_q[$];
  logic [18:0] sb_exp;

  typedef struct {
    logic [2:0] src1;
    logic [2:0] src2;
    logic [2:0] dest;
    logic       writes;
    logic       valid;
    logic       exp_ready;
  } hz_vec_t;

  hz_vec_t vecs[10];

  wb_scoreboard dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_src1   (issue_src1),
    .issue_src2   (issue_src2),
    .issue_dest   (issue_dest),
    .issue_writes (issue_writes),
    .res_valid    (res_valid),
    .res_ready    (res_ready),
    .res_dest     (res_dest),
    .res_data     (res_data),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_hold      (wr_hold),
    .busy_mask    (busy_mask),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] d);
    issue_valid  = 1'b1;
    issue_writes = 1'b1;
    issue_dest   = d;
    issue_src1   = 3'd0;
    issue_src2   = 3'd0;
    tick();
    issue_valid  = 1'b0;
    issue_writes = 1'b0;
  endtask

  task automatic send(input logic [2:0] d, input logic [15:0] v);
    res_valid = 1'b1;
    res_dest  = d;
    res_data  = v;
    tick();
    res_valid = 1'b0;
  endtask

  // Scoreboard: check each retiring write against the oldest accepted result.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (wr_en && !wr_hold) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL wb_unexpected: write addr=%0d data=%h, want no write", wr_addr, wr_data);
        end else begin
          sb_exp = sb_q.pop_front();
          chk("wb_write", {13'b0, wr_addr, wr_data}, {13'b0, sb_exp});
        end
      end
      if (res_valid && res_ready) begin
        sb_q.push_back({res_dest, res_data});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // busy_mask = regs 1 and 6 pending while the table runs
    vecs[0] = '{3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1};
    vecs[1] = '{3'd1, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{3'd0, 3'd6, 3'd0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{3'd2, 3'd3, 3'd6, 1'b0, 1'b1, 1'b1};
    vecs[4] = '{3'd2, 3'd3, 3'd6, 1'b1, 1'b0, 1'b0};
    vecs[5] = '{3'd2, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0};
    vecs[6] = '{3'd6, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0};
    vecs[7] = '{3'd7, 3'd7, 3'd7, 1'b1, 1'b0, 1'b1};
    vecs[8] = '{3'd2, 3'd3, 3'd4, 1'b1, 1'b0, 1'b1};
    vecs[9] = '{3'd5, 3'd6, 3'd7, 1'b0, 1'b0, 1'b0};

    issue_valid  = 1'b0;
    issue_src1   = 3'd0;
    issue_src2   = 3'd0;
    issue_dest   = 3'd0;
    issue_writes = 1'b0;
    res_valid    = 1'b0;
    res_dest     = 3'd0;
    res_data     = 16'h0;
    wr_hold      = 1'b0;
    rst_n        = 1'b1;

    // Reset state
    #2 rst_n = 1'b0;
    #1;
    chk("rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("rst_wr_addr", {29'b0, wr_addr}, 32'd0);
    chk("rst_wr_data", {16'b0, wr_data}, 32'd0);
    chk("rst_busy", {24'b0, busy_mask}, 32'd0);
    chk("rst_err", {31'b0, err}, 32'd0);
    chk("rst_res_ready", {31'b0, res_ready}, 32'd1);
    chk("rst_issue_ready", {31'b0, issue_ready}, 32'd1);
    tick();
    rst_n = 1'b1;

    // Basic write-back
    issue(3'd3);
    chk("basic_busy_set", {24'b0, busy_mask}, 32'h08);
    issue_src1 = 3'd3;
    #1 chk("basic_raw_stall", {31'b0, issue_ready}, 32'd0);
    send(3'd3, 16'hBEEF);
    chk("basic_wr_en", {31'b0, wr_en}, 32'd1);
    chk("basic_wr_addr", {29'b0, wr_addr}, 32'd3);
    chk("basic_wr_data", {16'b0, wr_data}, 32'hBEEF);
    tick();
    chk("basic_busy_clr", {24'b0, busy_mask}, 32'h00);
    chk("basic_ready_back", {31'b0, issue_ready}, 32'd1);
    chk("basic_idle", {31'b0, wr_en}, 32'd0);
    issue_src1 = 3'd0;

    // Retire/issue race: source visible busy during the retiring cycle
    issue(3'd2);
    send(3'd2, 16'h1234);
    issue_src2 = 3'd2;
    #1 chk("race_ready_now", {31'b0, issue_ready}, 32'd0);
    tick();
    chk("race_ready_next", {31'b0, issue_ready}, 32'd1);
    issue_src2 = 3'd0;

    // Backpressure: fill output register and FIFO, then drain
    wr_hold = 1'b1;
    issue(3'd1);
    issue(3'd2);
    issue(3'd4);
    chk("bp_busy", {24'b0, busy_mask}, 32'h16);
    send(3'd1, 16'hA001);
    chk("bp_first_out", {28'b0, wr_en, wr_addr}, {28'b0, 1'b1, 3'd1});
    chk("bp_ready1", {31'b0, res_ready}, 32'd1);
    send(3'd2, 16'hA002);
    chk("bp_ready2", {31'b0, res_ready}, 32'd1);
    send(3'd4, 16'hA004);
    chk("bp_full", {31'b0, res_ready}, 32'd0);
    res_valid = 1'b1;
    res_dest  = 3'd4;
    res_data  = 16'hFFFF;
    tick();
    res_valid = 1'b0;
    chk("bp_still_full", {31'b0, res_ready}, 32'd0);
    chk("bp_held_addr", {29'b0, wr_addr}, 32'd1);
    wr_hold = 1'b0;
    tick();
    chk("bp_drain_addr2", {29'b0, wr_addr}, 32'd2);
    chk("bp_ready_back", {31'b0, res_ready}, 32'd1);
    chk("bp_busy_after1", {24'b0, busy_mask}, 32'h14);
    tick();
    chk("bp_drain_addr4", {29'b0, wr_addr}, 32'd4);
    chk("bp_busy_after2", {24'b0, busy_mask}, 32'h10);
    tick();
    chk("bp_drained", {31'b0, wr_en}, 32'd0);
    chk("bp_busy_clear", {24'b0, busy_mask}, 32'h00);

    // WAW stall until reg 5 retires, then the held instruction issues
    issue(3'd5);
    issue_valid  = 1'b1;
    issue_writes = 1'b1;
    issue_dest   = 3'd5;
    issue_src1   = 3'd0;
    issue_src2   = 3'd0;
    #1 chk("waw_stall", {31'b0, issue_ready}, 32'd0);
    tick();
    chk("waw_stall_hold", {31'b0, issue_ready}, 32'd0);
    send(3'd5, 16'h5555);
    chk("waw_stall_writing", {31'b0, issue_ready}, 32'd0);
    tick();
    chk("waw_release", {31'b0, issue_ready}, 32'd1);
    tick();
    issue_valid  = 1'b0;
    issue_writes = 1'b0;
    chk("waw_issued", {24'b0, busy_mask}, 32'h20);
    send(3'd5, 16'h5556);
    tick();
    chk("waw_cleared", {24'b0, busy_mask}, 32'h00);

    // Protocol error: result for a register that is not pending
    chk("err_before", {31'b0, err}, 32'd0);
    send(3'd6, 16'h0666);
    chk("err_set", {31'b0, err}, 32'd1);
    chk("err_wr", {28'b0, wr_en, wr_addr}, {28'b0, 1'b1, 3'd6});
    chk("err_wr_data", {16'b0, wr_data}, 32'h0666);
    tick();
    chk("err_sticky", {31'b0, err}, 32'd1);
    chk("err_busy", {24'b0, busy_mask}, 32'h00);

    // Hazard vector table
    issue(3'd1);
    issue(3'd6);
    chk("tbl_busy", {24'b0, busy_mask}, 32'h42);
    for (int i = 0; i < 10; i++) begin
      issue_src1   = vecs[i].src1;
      issue_src2   = vecs[i].src2;
      issue_dest   = vecs[i].dest;
      issue_writes = vecs[i].writes;
      issue_valid  = vecs[i].valid;
      #1 chk($sformatf("tbl_ready_%0d", i), {31'b0, issue_ready}, {31'b0, vecs[i].exp_ready});
      tick();
    end
    issue_valid  = 1'b0;
    issue_writes = 1'b0;
    issue_src1   = 3'd0;
    issue_src2   = 3'd0;
    chk("tbl_busy_kept", {24'b0, busy_mask}, 32'h42);
    send(3'd1, 16'h1111);
    send(3'd6, 16'h6666);
    tick();
    chk("tbl_cleared", {24'b0, busy_mask}, 32'h00);

    // Reset mid-operation with two results buffered
    issue(3'd2);
    issue(3'd3);
    wr_hold = 1'b1;
    send(3'd2, 16'hC002);
    send(3'd3, 16'hC003);
    chk("mid_busy", {24'b0, busy_mask}, 32'h0C);
    chk("mid_wr_en", {31'b0, wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_wr_en", {31'b0, wr_en}, 32'd0);
    chk("mid_rst_busy", {24'b0, busy_mask}, 32'h00);
    chk("mid_rst_res_ready", {31'b0, res_ready}, 32'd1);
    chk("mid_rst_err", {31'b0, err}, 32'd0);
    tick();
    rst_n   = 1'b1;
    wr_hold = 1'b0;
    tick();
    tick();
    chk("mid_discarded", {31'b0, wr_en}, 32'd0);

    tick();
    chk("sb_empty", sb_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_scoreboard.md
Name: wb_scoreboard

Overview:
- Write-back and hazard stage in front of the 8x16 register bank.
- Accepts ALU results through a valid/ready handshake and buffers them in a 2-entry FIFO.
- Presents the buffered results to the bank one write per cycle on registered outputs.
- Keeps a per-register pending scoreboard. Decode uses it to stall any instruction whose sources or destination have an outstanding write (RAW and WAW).

Parameters:
DATA_W, 16, result/register data width
ADDR_W, 3, register address width
NREGS, 8, number of architectural registers (2**ADDR_W)
FIFO_DEPTH, 2, write-back buffer entries, excluding the output register

Ports:
clk  in  1  single system clock, rising edge
rst_n  in  1  asynchronous active-low reset
issue_valid  in  1  decode presents an instruction
issue_ready  out  1  combinational; 1 = no hazard, instruction may issue
issue_src1  in  ADDR_W  first source register
issue_src2  in  ADDR_W  second source register
issue_dest  in  ADDR_W  destination register
issue_writes  in  1  instruction writes issue_dest
res_valid  in  1  ALU result valid
res_ready  out  1  combinational; equals !fifo_full
res_dest  in  ADDR_W  result destination
res_data  in  DATA_W  result value
wr_en  out  1  registered write strobe to the bank
wr_addr  out  ADDR_W  registered write address
wr_data  out  DATA_W  registered write data
wr_hold  in  1  bank cannot accept the write this cycle
busy_mask  out  NREGS  registered pending bits, bit i = register i
err  out  1  sticky protocol error

Behaviour:
- Reset (async, rst_n=0):
  - Clears busy_mask, FIFO and err.
  - Sets wr_en=0, wr_addr=0, wr_data=0.
  - Outputs settle to res_ready=1 and issue_ready=1.
  - Asserting reset mid-operation discards all buffered results and pending state.
- Hazard rule: issue_ready=0 when any of the following holds, otherwise 1.
  - busy_mask[issue_src1]=1.
  - busy_mask[issue_src2]=1.
  - issue_writes=1 and busy_mask[issue_dest]=1.
- issue_ready is computed from the current registered busy_mask only. It is independent of issue_valid.
- Issue fires when issue_valid & issue_ready & issue_writes. At that edge busy_mask[issue_dest] is set.
- Result accept fires when res_valid & res_ready. The entry {res_dest, res_data} enters the write-back path.
  - If res_dest is not pending, err sets to 1 and stays set until reset; the write still proceeds.
- Output register load: the output register may load when wr_en=0, or when wr_en=1 & wr_hold=0.
  - If it may load and the FIFO is non-empty: load the FIFO head and pop it. wr_en=1.
  - Else if it may load, the FIFO is empty and an accept fires: bypass the FIFO and load the incoming result directly. Latency is 1 cycle.
  - Else if it may load: wr_en=0. wr_addr and wr_data hold their last values.
  - If the output register holds, an accepted result is pushed to the FIFO.
- Ordering is strict FIFO; results are never reordered.
- Retire: at an edge where wr_en=1 & wr_hold=0, busy_mask[wr_addr] clears. The bank has taken the write in that cycle.
  - An instruction reading that register can issue in the following cycle.
- Simultaneous set and clear on the same register: set wins. This is unreachable because the WAW stall blocks it.
- Full FIFO: res_ready=0. No pass-through when a pop coincides; res_ready follows FIFO occupancy only.
- Capacity: at most FIFO_DEPTH + 1 results are held (FIFO plus output register).
- FIFO pointers wrap modulo FIFO_DEPTH. An occupancy counter of width clog2(FIFO_DEPTH+1) distinguishes full from empty.
- busy_mask is the registered scoreboard itself.

Test Plan:
- Reset mid-operation: reset with busy_mask=8'h0C and 2 entries buffered -> immediately wr_en=0, busy_mask=0, res_ready=1, err=0.
- Basic write-back:
  - Issue dest=3 -> busy_mask=8'h08.
  - Present src1=3 -> issue_ready=0.
  - res_dest=3, res_data=16'hBEEF -> next cycle wr_en=1, wr_addr=3, wr_data=BEEF.
  - Following cycle busy_mask=0, issue_ready=1.
- Backpressure:
  - Pending regs 1, 2, 4 with wr_hold=1; send results for 1, 2, 4 -> after the third accept, res_ready=0.
  - Drop wr_hold -> writes to 1, 2, 4 on three consecutive cycles; res_ready returns to 1 after the first retire.
- WAW stall: reg 5 pending; issue dest=5 with src1=src2=0 -> issue_ready=0 until reg 5 retires.
- Protocol error: result for reg 6 with busy_mask[6]=0 -> err=1 sticky, wr_en=1, wr_addr=6 next cycle.
- Retire/issue race: src2=2 presented in the cycle reg 2 is being written (wr_hold=0) -> issue_ready=0 that cycle, 1 the next.
